// File: rtl/dram_wr_ctl_if.sv
// Data-RAM write bus: word-aligned beats with byte enables, held until acked.
// The controller drives the master side; the RAM drives mem_ack_i.
interface dram_wr_ctl_if #(
    parameter int XLEN = 32
);
    logic            mem_wr_en_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wr_data_o;
    logic [3:0]      mem_byte_en_o;
    logic            mem_ack_i;

    modport master (
        output mem_wr_en_o,
        output mem_addr_o,
        output mem_wr_data_o,
        output mem_byte_en_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_wr_en_o,
        input  mem_addr_o,
        input  mem_wr_data_o,
        input  mem_byte_en_o,
        output mem_ack_i
    );
endinterface

// File: rtl/dram_wr_ctl.sv
// Store-side write controller: turns a byte/half/word store into one or two
// word-aligned write beats with byte enables; misaligned stores are split.
module dram_wr_ctl #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_req_i,
    input  logic [2:0]        wr_sel_i,
    input  logic [XLEN-1:0]   wr_addr_i,
    input  logic [XLEN-1:0]   wr_data_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    dram_wr_ctl_if.master     mem
);

    localparam logic [2:0] DRAM_WR_B = 3'd1;
    localparam logic [2:0] DRAM_WR_H = 3'd2;
    localparam logic [2:0] DRAM_WR_W = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic              ready_q, done_q, err_q, err_d;
    logic              en_q, en_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   hi_addr_q, hi_addr_d;
    logic [XLEN-1:0]   hi_data_q, hi_data_d;
    logic [3:0]        hi_be_q, hi_be_d;

    logic              valid_sel;
    logic [3:0]        lane_base;
    logic [7:0]        mask;
    logic [63:0]       wide;
    logic [63:0]       lane_data;
    logic [XLEN-1:0]   word_addr;

    // Request decode: an 8-lane window spanning this word and the next one.
    always_comb begin
        valid_sel = 1'b1;
        lane_base = '0;
        case (wr_sel_i)
            DRAM_WR_B: lane_base = 4'b0001;
            DRAM_WR_H: lane_base = 4'b0011;
            DRAM_WR_W: lane_base = 4'b1111;
            default:   valid_sel = 1'b0;
        endcase
        mask      = {4'b0000, lane_base} << wr_addr_i[1:0];
        wide      = {32'b0, wr_data_i} << {wr_addr_i[1:0], 3'b000};
        lane_data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lane_data[8*i +: 8] = mask[i] ? wide[8*i +: 8] : 8'h00;
        end
        word_addr = {wr_addr_i[XLEN-1:2], 2'b00};
    end

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        en_d      = en_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        hi_be_d   = hi_be_q;
        case (state_q)
            IDLE: begin
                if (wr_req_i) begin
                    if (valid_sel) begin
                        state_d   = BEAT0;
                        en_d      = 1'b1;
                        addr_d    = word_addr;
                        data_d    = lane_data[31:0];
                        be_d      = mask[3:0];
                        hi_addr_d = word_addr + XLEN'(4);
                        hi_data_d = lane_data[63:32];
                        hi_be_d   = mask[7:4];
                    end else begin
                        state_d = FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (mem.mem_ack_i) begin
                    if (hi_be_q != '0) begin
                        state_d = BEAT1;
                        addr_d  = hi_addr_q;
                        data_d  = hi_data_q;
                        be_d    = hi_be_q;
                    end else begin
                        state_d = FIN;
                        en_d    = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        be_d    = '0;
                    end
                end
            end
            BEAT1: begin
                if (mem.mem_ack_i) begin
                    state_d = FIN;
                    en_d    = 1'b0;
                    addr_d  = '0;
                    data_d  = '0;
                    be_d    = '0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so every output is a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            hi_addr_q <= '0;
            hi_data_q <= '0;
            hi_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == IDLE);
            done_q    <= (state_d == FIN);
            err_q     <= err_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            hi_be_q   <= hi_be_d;
        end
    end

    assign ready_o           = ready_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign mem.mem_wr_en_o   = en_q;
    assign mem.mem_addr_o    = addr_q;
    assign mem.mem_wr_data_o = data_q;
    assign mem.mem_byte_en_o = be_q;

endmodule
